// File: rtl/dino_pkg.sv
// Shared definitions for the Dino game obstacle path: screen geometry,
// spawner defaults, cactus kinds and the spawner state encoding.
package dino_pkg;

    localparam int SCREEN_W      = 640;
    localparam int X_START_DEF   = 640;
    localparam int SPEED_DEF     = 2;
    localparam int MIN_GAP_DEF   = 40;
    localparam int GAP_SHIFT_DEF = 2;

    typedef enum logic [1:0] {
        SMALL  = 2'd0,
        TALL   = 2'd1,
        DOUBLE = 2'd2,
        WIDE   = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GAP = 2'd1,
        REQ      = 2'd2,
        SPAWN    = 2'd3
    } spawner_state_e;

endpackage

// File: rtl/cactus_slot.sv
// One on-screen cactus: active flag, x position and kind, with load,
// left-scroll and retire-at-left-edge behaviour.
module cactus_slot
    import dino_pkg::*;
#(
    parameter int X_W     = 10,
    parameter int X_START = X_START_DEF,
    parameter int SPEED   = SPEED_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           scroll_i,
    input  kind_e          kind_i,
    output logic           active_o,
    output logic [X_W-1:0] x_o,
    output kind_e          kind_o
);

    logic           active_q, active_d;
    logic [X_W-1:0] x_q, x_d;
    kind_e          kind_q, kind_d;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        kind_d   = kind_q;
        // A freshly loaded cactus is not scrolled in its load cycle.
        if (load_i) begin
            active_d = 1'b1;
            x_d      = X_W'(X_START);
            kind_d   = kind_i;
        end else if (scroll_i && active_q) begin
            if (x_q <= X_W'(SPEED)) begin
                active_d = 1'b0;
            end else begin
                x_d = x_q - X_W'(SPEED);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            x_q      <= '0;
            kind_q   <= SMALL;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            kind_q   <= kind_d;
        end
    end

    assign active_o = active_q;
    assign x_o      = x_q;
    assign kind_o   = kind_q;

endmodule

// File: rtl/cactus_spawner.sv
// Cactus spawner: gap timer, RNG handshake, free-slot selection and the slot array.
// Optional statistics outputs are enabled by defining SPAWNER_STATS_EN.
module cactus_spawner
    import dino_pkg::*;
#(
    parameter int SLOTS     = 4,
    parameter int X_W       = 10,
    parameter int X_START   = X_START_DEF,
    parameter int SPEED     = SPEED_DEF,
    parameter int MIN_GAP   = MIN_GAP_DEF,
    parameter int GAP_SHIFT = GAP_SHIFT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 run,
    input  logic [4:0]           rand_in,
    input  logic                 rand_valid,
    output logic                 rand_req,
    output logic                 spawn_pulse,
`ifdef SPAWNER_STATS_EN
    output logic [7:0]           spawn_count,
    output logic [7:0]           drop_count,
`endif
    output logic [SLOTS-1:0]     cactus_active,
    output logic [SLOTS*X_W-1:0] cactus_x,
    output logic [SLOTS*2-1:0]   cactus_kind
);

    // Counter wide enough for the largest reload, never narrower than 7 bits.
    localparam int GAP_MAX   = MIN_GAP + (31 << GAP_SHIFT);
    localparam int GAP_W_RAW = $clog2(GAP_MAX + 1);
    localparam int GAP_W     = (GAP_W_RAW < 7) ? 7 : GAP_W_RAW;

    spawner_state_e   state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             rand_req_q, rand_req_d;
    logic             spawn_pulse_q, spawn_pulse_d;
    logic [SLOTS-1:0] free_oh;
    logic             free_any;
    logic [SLOTS-1:0] load;
    logic             scroll;

    assign scroll = tick & run;

    always_comb begin
        free_oh  = '0;
        free_any = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!cactus_active[i] && !free_any) begin
                free_oh[i] = 1'b1;
                free_any   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        rand_req_d    = 1'b0;
        spawn_pulse_d = 1'b0;
        load          = '0;
        if (!run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    gap_d   = GAP_W'(MIN_GAP);
                    state_d = WAIT_GAP;
                end
                WAIT_GAP, SPAWN: begin
                    state_d = WAIT_GAP;
                    if (tick) begin
                        if (gap_q <= GAP_W'(1)) begin
                            gap_d      = '0;
                            state_d    = REQ;
                            rand_req_d = 1'b1;
                        end else begin
                            gap_d = gap_q - GAP_W'(1);
                        end
                    end
                end
                REQ: begin
                    rand_req_d = 1'b1;
                    // The slot write and gap reload both commit on the handshake edge.
                    if (rand_valid) begin
                        rand_req_d    = 1'b0;
                        state_d       = SPAWN;
                        gap_d         = GAP_W'(MIN_GAP) + (GAP_W'(rand_in) << GAP_SHIFT);
                        load          = free_oh;
                        spawn_pulse_d = free_any;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gap_q         <= '0;
            rand_req_q    <= 1'b0;
            spawn_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            rand_req_q    <= rand_req_d;
            spawn_pulse_q <= spawn_pulse_d;
        end
    end

    assign rand_req    = rand_req_q;
    assign spawn_pulse = spawn_pulse_q;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        cactus_slot #(
            .X_W     (X_W),
            .X_START (X_START),
            .SPEED   (SPEED)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load[g]),
            .scroll_i (scroll),
            .kind_i   (kind_e'(rand_in[1:0])),
            .active_o (cactus_active[g]),
            .x_o      (cactus_x[g*X_W +: X_W]),
            .kind_o   (cactus_kind[g*2 +: 2])
        );
    end

`ifdef SPAWNER_STATS_EN
    logic [7:0] spawn_cnt_q;
    logic [7:0] drop_cnt_q;
    logic       drop_event;

    assign drop_event = run && (state_q == REQ) && rand_valid && !free_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (spawn_pulse_d && (spawn_cnt_q != 8'hFF)) spawn_cnt_q <= spawn_cnt_q + 8'd1;
            if (drop_event && (drop_cnt_q != 8'hFF))     drop_cnt_q  <= drop_cnt_q + 8'd1;
        end
    end

    assign spawn_count = spawn_cnt_q;
    assign drop_count  = drop_cnt_q;
`endif

endmodule
